// File: rtl/rng_responder.sv
// Responder side of the key-gen RNG handshake: one W-bit pseudo-random word per request,
// taken from a Fibonacci LFSR that advances DIGIT steps per clock while busy.
module rng_responder #(
    parameter int           W         = 96,
    parameter int           DIGIT     = 8,
    parameter logic [W-1:0] SEED_DFLT = {{(W-1){1'b0}}, 1'b1}
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         rng_start_i,
    input  logic         rng_in_mod_i,
    input  logic [W-1:0] rng_seed_i,
    output logic [W-1:0] rng_data_o,
    output logic         rng_finish_o,
    output logic         rng_busy_o
);

    localparam int N     = W / DIGIT;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state_q;
    logic [W-1:0]   lfsr_q;
    logic [W-1:0]   lfsr_d;
    logic [CNT_W-1:0] cnt_q;
    logic [W-1:0]   data_q;
    logic           finish_q;
    logic           busy_q;

    // DIGIT chained single steps; each step feeds the next within one clock.
    function automatic logic [W-1:0] lfsr_adv(input logic [W-1:0] s);
        logic [W-1:0] r;
        logic         fb;
        r = s;
        for (int k = 0; k < DIGIT; k++) begin
            fb = r[95] ^ r[93] ^ r[48] ^ r[46];
            r  = {r[W-2:0], fb};
        end
        return r;
    endfunction

    always_comb begin
        lfsr_d = lfsr_adv(lfsr_q);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            lfsr_q   <= SEED_DFLT;
            cnt_q    <= '0;
            data_q   <= '0;
            finish_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    finish_q <= 1'b0;
                    if (rng_start_i) begin
                        state_q <= BUSY;
                        busy_q  <= 1'b1;
                        cnt_q   <= '0;
                        // An all-zero seed would lock the LFSR, so substitute the default.
                        if (rng_in_mod_i) begin
                            lfsr_q <= (rng_seed_i == '0) ? SEED_DFLT : rng_seed_i;
                        end
                    end
                end
                BUSY: begin
                    lfsr_q <= lfsr_d;
                    if (cnt_q == CNT_W'(N - 1)) begin
                        state_q  <= DONE;
                        data_q   <= lfsr_d;
                        finish_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                DONE: begin
                    state_q  <= IDLE;
                    finish_q <= 1'b0;
                    busy_q   <= 1'b0;
                end
                default: begin
                    state_q  <= IDLE;
                    finish_q <= 1'b0;
                    busy_q   <= 1'b0;
                end
            endcase
        end
    end

    assign rng_data_o   = data_q;
    assign rng_finish_o = finish_q;
    assign rng_busy_o   = busy_q;

endmodule

// File: tb/tb_rng_responder.sv
// Randomized self-checking bench for rng_responder against a plain LFSR stream model,
// with instances at DIGIT = 8, 1 and 96 sharing control inputs.
module tb_rng_responder;

    localparam logic [95:0] DFLT = 96'h1;
    localparam logic [95:0] SEED2 = 96'h0123_4567_89AB_CDEF_0011_2233;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start8 = 1'b0, start1 = 1'b0, start96 = 1'b0;
    logic        in_mod = 1'b0;
    logic [95:0] seed = '0;
    logic [95:0] data8, data1, data96;
    logic        fin8, fin1, fin96;
    logic        busy8, busy1, busy96;

    int nchecks = 0;
    int nerr    = 0;

    logic [95:0] m8;
    logic [95:0] word1;

    always #5 clk = ~clk;

    rng_responder #(.W(96), .DIGIT(8)) u8 (
        .clk_i(clk), .rst_i(rst), .rng_start_i(start8), .rng_in_mod_i(in_mod),
        .rng_seed_i(seed), .rng_data_o(data8), .rng_finish_o(fin8), .rng_busy_o(busy8));
    rng_responder #(.W(96), .DIGIT(1)) u1 (
        .clk_i(clk), .rst_i(rst), .rng_start_i(start1), .rng_in_mod_i(in_mod),
        .rng_seed_i(seed), .rng_data_o(data1), .rng_finish_o(fin1), .rng_busy_o(busy1));
    rng_responder #(.W(96), .DIGIT(96)) u96 (
        .clk_i(clk), .rst_i(rst), .rng_start_i(start96), .rng_in_mod_i(in_mod),
        .rng_seed_i(seed), .rng_data_o(data96), .rng_finish_o(fin96), .rng_busy_o(busy96));

    task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
        nchecks++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: advance the stream n single steps.
    function automatic logic [95:0] adv(input logic [95:0] s, input int n);
        logic [95:0] r;
        r = s;
        for (int i = 0; i < n; i++) r = {r[94:0], r[95] ^ r[93] ^ r[48] ^ r[46]};
        return r;
    endfunction

    function automatic logic [95:0] rnd96();
        return {$urandom(), $urandom(), $urandom()};
    endfunction

    function automatic logic fin_of(input int w);
        case (w)
            1:       return fin1;
            96:      return fin96;
            default: return fin8;
        endcase
    endfunction

    function automatic logic busy_of(input int w);
        case (w)
            1:       return busy1;
            96:      return busy96;
            default: return busy8;
        endcase
    endfunction

    function automatic logic [95:0] data_of(input int w);
        case (w)
            1:       return data1;
            96:      return data96;
            default: return data8;
        endcase
    endfunction

    task automatic set_start(input int w, input logic v);
        case (w)
            1:       start1 = v;
            96:      start96 = v;
            default: start8 = v;
        endcase
    endtask

    // One request on instance with DIGIT=w; checks latency, single pulse, word and return to idle.
    task automatic req(input int w, input logic mod, input logic [95:0] sd,
                       input logic [95:0] exp, input string tag);
        int n, first, cnt;
        logic [95:0] got;
        n = 96 / w;
        first = -1; cnt = 0; got = '0;
        @(negedge clk);
        set_start(w, 1'b1); in_mod = mod; seed = sd;
        @(posedge clk); @(negedge clk);
        set_start(w, 1'b0); in_mod = 1'b0;
        check({tag, "_busy"}, 96'(busy_of(w)), 96'd1);
        for (int k = 1; k <= n + 4; k++) begin
            @(posedge clk); @(negedge clk);
            if (fin_of(w)) begin
                cnt++;
                if (first < 0) begin
                    first = k;
                    got = data_of(w);
                end
            end
        end
        check({tag, "_latency"}, 96'(first), 96'(n));
        check({tag, "_pulses"}, 96'(cnt), 96'd1);
        check({tag, "_word"}, got, exp);
        check({tag, "_held"}, data_of(w), exp);
        check({tag, "_idle"}, 96'(busy_of(w)), 96'd0);
    endtask

    initial begin
        // Reset
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_data8", data8, '0);
        check("rst_fin8", 96'(fin8), '0);
        check("rst_busy8", 96'(busy8), '0);
        check("rst_data1", data1, '0);
        check("rst_data96", data96, '0);
        rst = 1'b0;
        m8 = adv(DFLT, 96);
        word1 = m8;
        req(8, 1'b0, rnd96(), m8, "first_word");

        // Reseed latency at DIGIT=8
        m8 = adv(SEED2, 96);
        req(8, 1'b1, SEED2, m8, "seed2");

        // Streaming with start held
        begin
            int fcount, last;
            fcount = 0; last = -1;
            @(negedge clk);
            start8 = 1'b1; in_mod = 1'b0;
            for (int cyc = 1; cyc <= 8 * 14 + 30; cyc++) begin
                @(posedge clk); @(negedge clk);
                if (fin8) begin
                    fcount++;
                    m8 = adv(m8, 96);
                    check("stream_word", data8, m8);
                    if (last >= 0) check("stream_period", 96'(cyc - last), 96'd14);
                    last = cyc;
                    if (fcount == 8) begin
                        start8 = 1'b0;
                        break;
                    end
                end
            end
            start8 = 1'b0;
            check("stream_count", 96'(fcount), 96'd8);
            fcount = 0;
            repeat (4) begin
                @(posedge clk); @(negedge clk);
                if (fin8) fcount++;
            end
            check("stream_drain", 96'(fcount), 96'd0);
        end

        // Zero seed behaves like the default seed
        m8 = adv(DFLT, 96);
        req(8, 1'b1, '0, m8, "zero_seed");
        req(8, 1'b1, DFLT, m8, "dflt_seed");

        // Randomized mix of reseeds and continuations
        for (int i = 0; i < 6; i++) begin
            logic        mod;
            logic [95:0] sd;
            mod = 1'($urandom_range(0, 1));
            sd  = ($urandom_range(0, 3) == 0) ? '0 : rnd96();
            if (mod) m8 = (sd == '0) ? DFLT : sd;
            m8 = adv(m8, 96);
            req(8, mod, sd, m8, "rand");
        end

        // Inputs toggled during BUSY and DONE are ignored
        begin
            logic [95:0] s5, got;
            int fins;
            s5 = rnd96();
            m8 = adv(s5, 96);
            fins = 0; got = '0;
            @(negedge clk);
            start8 = 1'b1; in_mod = 1'b1; seed = s5;
            @(posedge clk); @(negedge clk);
            for (int k = 1; k <= 20; k++) begin
                start8 = 1'($urandom_range(0, 1));
                in_mod = 1'($urandom_range(0, 1));
                seed = rnd96();
                @(posedge clk); @(negedge clk);
                if (fin8) begin
                    fins++;
                    got = data8;
                    start8 = 1'b1; in_mod = 1'b1; seed = rnd96();
                    @(posedge clk); @(negedge clk);
                    start8 = 1'b0; in_mod = 1'b0;
                    check("ign_idle", 96'(busy8), 96'd0);
                    break;
                end
            end
            start8 = 1'b0;
            repeat (4) begin
                @(posedge clk); @(negedge clk);
                if (fin8) fins++;
            end
            check("ign_pulses", 96'(fins), 96'd1);
            check("ign_word", got, m8);
            m8 = adv(m8, 96);
            req(8, 1'b0, rnd96(), m8, "ign_continue");
        end

        // Reset in the middle of BUSY abandons the word
        begin
            int fins;
            fins = 0;
            @(negedge clk);
            start8 = 1'b1; in_mod = 1'b1; seed = rnd96();
            @(posedge clk); @(negedge clk);
            start8 = 1'b0; in_mod = 1'b0;
            repeat (4) @(posedge clk);
            @(negedge clk);
            rst = 1'b1;
            repeat (2) begin
                @(posedge clk); @(negedge clk);
                if (fin8) fins++;
            end
            rst = 1'b0;
            repeat (16) begin
                @(posedge clk); @(negedge clk);
                if (fin8) fins++;
            end
            check("midrst_nofinish", 96'(fins), 96'd0);
            check("midrst_busy", 96'(busy8), 96'd0);
            m8 = adv(DFLT, 96);
            req(8, 1'b0, rnd96(), word1, "midrst_word");
        end

        // Same reseed at DIGIT=1 and DIGIT=96
        req(1, 1'b1, SEED2, adv(SEED2, 96), "digit1");
        req(96, 1'b1, SEED2, adv(SEED2, 96), "digit96");
        req(96, 1'b0, rnd96(), adv(SEED2, 192), "digit96_next");

        $display("Result: errors=%0d of %0d checks", nerr, nchecks);
        $finish;
    end

endmodule
